// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way data-cache storage array: default
// geometry and the flush engine state encoding.
package dcache_pkg;

    localparam int DCACHE_WAYS   = 2;
    localparam int DCACHE_SETS   = 16;
    localparam int DCACHE_TAG_W  = 25;
    localparam int DCACHE_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } flush_state_e;

endpackage

// File: rtl/dcache_lru_age.sv
// Combinational true-LRU helper for one set: chooses the replacement victim
// and computes the age vector after an access.
module dcache_lru_age #(
    parameter int WAYS  = 2,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]            valid_i,
    input  logic [WAYS-1:0][WAY_W-1:0] age_i,
    input  logic [WAY_W-1:0]           access_way_i,
    output logic [WAY_W-1:0]           victim_o,
    output logic [WAYS-1:0][WAY_W-1:0] age_next_o
);

    logic             any_invalid;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] max_way;
    logic [WAY_W-1:0] max_age;
    logic [WAY_W-1:0] old_age;

    // Invalid ways are always preferred so a fill never evicts live data early.
    always_comb begin
        any_invalid = 1'b0;
        inv_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                any_invalid = 1'b1;
                inv_way     = WAY_W'(w);
            end
        end
        max_way = '0;
        max_age = age_i[0];
        for (int w = 1; w < WAYS; w++) begin
            if (age_i[w] > max_age) begin
                max_age = age_i[w];
                max_way = WAY_W'(w);
            end
        end
        victim_o = any_invalid ? inv_way : max_way;
    end

    always_comb begin
        old_age    = age_i[access_way_i];
        age_next_o = age_i;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == access_way_i) begin
                age_next_o[w] = '0;
            end else if (age_i[w] < old_age) begin
                age_next_o[w] = age_i[w] + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU replacement and a
// flush engine that streams dirty lines out over a valid/ready port.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int  WAYS   = DCACHE_WAYS,
    parameter int  SETS   = DCACHE_SETS,
    parameter int  TAG_W  = DCACHE_TAG_W,
    parameter int  LINE_W = DCACHE_LINE_W,
    localparam int SET_W  = $clog2(SETS),
    localparam int WAY_W  = $clog2(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [SET_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    output logic              hit_o,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    input  logic              flush_i,
    input  logic              flush_inv_i,
    output logic              busy_o,
    output logic              flush_done_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [SET_W-1:0]  wb_set_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o
);

    flush_state_e state_q, state_d;
    logic [SET_W-1:0] set_ptr_q, set_ptr_d;
    logic [WAY_W-1:0] way_ptr_q, way_ptr_d;
    logic             inv_q, inv_d;

    logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]            dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q, age_d;
    logic [TAG_W-1:0]                     tag_q  [SETS][WAYS];
    logic [LINE_W-1:0]                    data_q [SETS][WAYS];

    logic [WAYS-1:0]            hit_vec;
    logic [WAY_W-1:0]           hit_way;
    logic [WAY_W-1:0]           victim_way;
    logic [WAY_W-1:0]           sel_way;
    logic [WAYS-1:0][WAY_W-1:0] age_upd;
    logic                       idle;
    logic                       write_en;
    logic                       lru_en;
    logic                       last_entry;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i);
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    dcache_lru_age #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_lru (
        .valid_i      (valid_q[addr_i]),
        .age_i        (age_q[addr_i]),
        .access_way_i (sel_way),
        .victim_o     (victim_way),
        .age_next_o   (age_upd)
    );

    assign hit_o   = |hit_vec;
    assign sel_way = hit_o ? hit_way : victim_way;
    assign valid_o = valid_q[addr_i][sel_way];
    assign dirty_o = dirty_q[addr_i][sel_way];
    assign tag_o   = tag_q[addr_i][sel_way];
    assign data_o  = data_q[addr_i][sel_way];

    // Accesses only commit while the flush engine is idle; a read miss leaves ages alone.
    assign idle       = (state_q == IDLE);
    assign write_en   = idle && enable_i && write_i;
    assign lru_en     = idle && enable_i && (write_i || hit_o);
    assign last_entry = (set_ptr_q == SET_W'(SETS - 1)) && (way_ptr_q == WAY_W'(WAYS - 1));

    always_comb begin
        state_d   = state_q;
        set_ptr_d = set_ptr_q;
        way_ptr_d = way_ptr_q;
        inv_d     = inv_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        age_d     = age_q;

        if (write_en) begin
            valid_d[addr_i][sel_way] = 1'b1;
            dirty_d[addr_i][sel_way] = dirty_i;
        end
        if (lru_en) begin
            age_d[addr_i] = age_upd;
        end

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    inv_d     = flush_inv_i;
                    set_ptr_d = '0;
                    way_ptr_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (valid_q[set_ptr_q][way_ptr_q] && dirty_q[set_ptr_q][way_ptr_q]) begin
                    state_d = EMIT;
                end else begin
                    if (inv_q) begin
                        valid_d[set_ptr_q][way_ptr_q] = 1'b0;
                    end
                    if (last_entry) begin
                        state_d = DONE;
                    end else begin
                        way_ptr_d = way_ptr_q + WAY_W'(1);
                        if (way_ptr_q == WAY_W'(WAYS - 1)) begin
                            set_ptr_d = set_ptr_q + SET_W'(1);
                        end
                    end
                end
            end
            EMIT: begin
                if (wb_ready_i) begin
                    dirty_d[set_ptr_q][way_ptr_q] = 1'b0;
                    if (inv_q) begin
                        valid_d[set_ptr_q][way_ptr_q] = 1'b0;
                    end
                    if (last_entry) begin
                        state_d = DONE;
                    end else begin
                        state_d   = SCAN;
                        way_ptr_d = way_ptr_q + WAY_W'(1);
                        if (way_ptr_q == WAY_W'(WAYS - 1)) begin
                            set_ptr_d = set_ptr_q + SET_W'(1);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            set_ptr_q <= '0;
            way_ptr_q <= '0;
            inv_q     <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            state_q   <= state_d;
            set_ptr_q <= set_ptr_d;
            way_ptr_q <= way_ptr_d;
            inv_q     <= inv_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            age_q     <= age_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
        end else if (write_en) begin
            tag_q[addr_i][sel_way]  <= tag_i;
            data_q[addr_i][sel_way] <= data_i;
        end
    end

    // Write-back fields are zeroed outside EMIT so the port is quiet when idle.
    assign busy_o       = !idle;
    assign flush_done_o = (state_q == DONE);
    assign wb_valid_o   = (state_q == EMIT);
    assign wb_set_o     = wb_valid_o ? set_ptr_q : '0;
    assign wb_tag_o     = wb_valid_o ? tag_q[set_ptr_q][way_ptr_q] : '0;
    assign wb_data_o    = wb_valid_o ? data_q[set_ptr_q][way_ptr_q] : '0;

endmodule
